// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, operand forwarding and a
// data-cache miss stall FSM. Define HAZARD_PERF_CNT_EN to add stall/flush/miss counters.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned SRC_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1_e,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2_e,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
  input  logic                      RegWrite_e,
  input  logic [SRC_WIDTH-1:0]      ResultSrc_e,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_w,
  input  logic                      RegWrite_m,
  input  logic                      RegWrite_w,
  input  logic                      PCSrc_e,
  input  logic                      dcache_miss_m,
  input  logic                      mem_ready,
  output logic                      en_f,
  output logic                      en_d,
  output logic                      en_e,
  output logic                      en_m,
  output logic                      flush_d_n,
  output logic                      flush_e_n,
  output logic [1:0]                ForwardA_e,
  output logic [1:0]                ForwardB_e
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               flush_count,
  output logic [31:0]               miss_count
`endif
);

  localparam logic [SRC_WIDTH-1:0]      SRC_LOAD = SRC_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    RESUME = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   load_use;

  assign load_use = RegWrite_e && (ResultSrc_e == SRC_LOAD) && (Rd_e != REG_ZERO) &&
                    ((Rd_e == Rs1_d) || (Rd_e == Rs2_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Miss stall freezes every stage with flushes released so the frozen registers hold.
  always_comb begin
    state_nxt = state;
    en_f      = 1'b1;
    en_d      = 1'b1;
    en_e      = 1'b1;
    en_m      = 1'b1;
    flush_d_n = 1'b1;
    flush_e_n = 1'b1;
    if (rst) begin
      state_nxt = IDLE;
      en_f      = 1'b0;
      en_d      = 1'b0;
      en_e      = 1'b0;
      en_m      = 1'b0;
      flush_d_n = 1'b0;
      flush_e_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dcache_miss_m) begin
            state_nxt = MISS;
            en_f      = 1'b0;
            en_d      = 1'b0;
            en_e      = 1'b0;
            en_m      = 1'b0;
          end else if (PCSrc_e) begin
            flush_d_n = 1'b0;
            flush_e_n = 1'b0;
          end else if (load_use) begin
            en_f      = 1'b0;
            en_d      = 1'b0;
            flush_e_n = 1'b0;
          end
        end
        MISS: begin
          if (mem_ready) state_nxt = RESUME;
          en_f = 1'b0;
          en_d = 1'b0;
          en_e = 1'b0;
          en_m = 1'b0;
        end
        RESUME: begin
          state_nxt = IDLE;
          en_f      = 1'b0;
          en_d      = 1'b0;
          en_e      = 1'b0;
          en_m      = 1'b0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Memory stage wins over writeback; x0 never forwards.
  always_comb begin
    ForwardA_e = 2'b00;
    ForwardB_e = 2'b00;
    if (!rst) begin
      if (RegWrite_m && (Rd_m != REG_ZERO) && (Rd_m == Rs1_e))      ForwardA_e = 2'b10;
      else if (RegWrite_w && (Rd_w != REG_ZERO) && (Rd_w == Rs1_e)) ForwardA_e = 2'b01;
      if (RegWrite_m && (Rd_m != REG_ZERO) && (Rd_m == Rs2_e))      ForwardB_e = 2'b10;
      else if (RegWrite_w && (Rd_w != REG_ZERO) && (Rd_w == Rs2_e)) ForwardB_e = 2'b01;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      miss_count   <= '0;
    end else begin
      if (!en_m)                    stall_cycles <= stall_cycles + 32'd1;
      if (!flush_d_n || !flush_e_n) flush_count  <= flush_count + 32'd1;
      if (state == IDLE && dcache_miss_m) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_hazard_ctrl;
  localparam int unsigned AW = 5;
  localparam int unsigned SW = 2;

  localparam logic [9:0] O_RST   = 10'b0000_00_00_00;
  localparam logic [9:0] O_DEF   = 10'b1111_11_00_00;
  localparam logic [9:0] O_STALL = 10'b0000_11_00_00;
  localparam logic [9:0] O_LU    = 10'b0011_10_00_00;
  localparam logic [9:0] O_BR    = 10'b1111_00_00_00;
  localparam logic [9:0] O_FA10  = 10'b1111_11_10_00;
  localparam logic [9:0] O_FA01  = 10'b1111_11_01_00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [AW-1:0] Rs1_d = '0, Rs2_d = '0, Rs1_e = '0, Rs2_e = '0, Rd_e = '0, Rd_m = '0, Rd_w = '0;
  logic          RegWrite_e = 0, RegWrite_m = 0, RegWrite_w = 0, PCSrc_e = 0;
  logic [SW-1:0] ResultSrc_e = '0;
  logic          dcache_miss_m = 0, mem_ready = 0;
  logic          en_f, en_d, en_e, en_m, flush_d_n, flush_e_n;
  logic [1:0]    ForwardA_e, ForwardB_e;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_count, miss_count;
`endif

  hazard_ctrl #(.REG_ADDR_WIDTH(AW), .SRC_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .Rs1_d(Rs1_d), .Rs2_d(Rs2_d), .Rs1_e(Rs1_e), .Rs2_e(Rs2_e),
    .Rd_e(Rd_e), .RegWrite_e(RegWrite_e), .ResultSrc_e(ResultSrc_e), .Rd_m(Rd_m), .Rd_w(Rd_w),
    .RegWrite_m(RegWrite_m), .RegWrite_w(RegWrite_w), .PCSrc_e(PCSrc_e),
    .dcache_miss_m(dcache_miss_m), .mem_ready(mem_ready), .en_f(en_f), .en_d(en_d),
    .en_e(en_e), .en_m(en_m), .flush_d_n(flush_d_n), .flush_e_n(flush_e_n),
    .ForwardA_e(ForwardA_e), .ForwardB_e(ForwardB_e)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  wire [9:0] dut_out = {en_f, en_d, en_e, en_m, flush_d_n, flush_e_n, ForwardA_e, ForwardB_e};

  // Model: phase 0 = running, 1 = waiting for refill, 2 = one drain cycle after refill.
  int phase = 0;

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (RegWrite_m && Rd_m != 0 && Rd_m == rs) return 2'b10;
    if (RegWrite_w && Rd_w != 0 && Rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] model_out(input int ph);
    logic [5:0] ctl;
    logic       lu;
    if (rst) return O_RST;
    lu = RegWrite_e && ResultSrc_e == 2'b01 && Rd_e != 0 && (Rd_e == Rs1_d || Rd_e == Rs2_d);
    if (ph != 0 || dcache_miss_m) ctl = 6'b0000_11;
    else if (PCSrc_e)             ctl = 6'b1111_00;
    else if (lu)                  ctl = 6'b0011_10;
    else                          ctl = 6'b1111_11;
    return {ctl, fwd(Rs1_e), fwd(Rs2_e)};
  endfunction

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] m_stall = '0, m_flush = '0, m_miss = '0;
`endif

  // Per-cycle compare against the model, then advance the model to the next cycle.
  initial forever begin
    logic [9:0] exp;
    @(negedge clk);
    exp = model_out(phase);
    chk("cycle_outputs", 32'(dut_out), 32'(exp));
`ifdef HAZARD_PERF_CNT_EN
    if (rst) begin
      m_stall = '0; m_flush = '0; m_miss = '0;
    end
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
    chk("miss_count", miss_count, m_miss);
    if (!rst) begin
      if (!exp[6])            m_stall = m_stall + 1;
      if (!exp[5] || !exp[4]) m_flush = m_flush + 1;
      if (phase == 0 && dcache_miss_m) m_miss = m_miss + 1;
    end
`endif
    if (rst)             phase = 0;
    else if (phase == 0) phase = dcache_miss_m ? 1 : 0;
    else if (phase == 1) phase = mem_ready ? 2 : 1;
    else                 phase = 0;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    {Rs1_d, Rs2_d, Rs1_e, Rs2_e, Rd_e, Rd_m, Rd_w} = '0;
    {RegWrite_e, RegWrite_m, RegWrite_w, PCSrc_e, dcache_miss_m, mem_ready} = '0;
    ResultSrc_e = '0;
  endtask

  task automatic lit(input string nm, input logic [9:0] exp);
    #4;
    chk(nm, 32'(dut_out), 32'(exp));
  endtask

  initial begin
    step(); lit("reset_outputs", O_RST);
    step(); rst = 0; lit("defaults_after_reset", O_DEF);

    step(); Rd_e = 5; ResultSrc_e = 2'b01; RegWrite_e = 1; Rs1_d = 5; lit("load_use", O_LU);
    step(); clr(); lit("load_use_released", O_DEF);

    step(); Rd_e = 5; ResultSrc_e = 2'b01; RegWrite_e = 1; Rs2_d = 5; PCSrc_e = 1;
    lit("branch_over_load_use", O_BR);
    step(); clr();
    Rs1_e = 3; Rd_m = 3; Rd_w = 3; RegWrite_m = 1; RegWrite_w = 1; lit("fwd_mem", O_FA10);
    step(); Rd_m = 0; lit("fwd_wb", O_FA01);
    step(); clr(); Rd_e = 0; Rs1_d = 0; RegWrite_e = 1; ResultSrc_e = 2'b01;
    lit("load_use_x0_ignored", O_DEF);

    step(); clr(); dcache_miss_m = 1; lit("miss_c0", O_STALL);
    for (int c = 1; c <= 5; c++) begin
      step(); dcache_miss_m = 0; mem_ready = (c == 4); lit("miss_stall", O_STALL);
    end
    step(); mem_ready = 0; lit("miss_c6_resume", O_DEF);
`ifdef HAZARD_PERF_CNT_EN
    #0 chk("miss_stall_cycles", stall_cycles, 32'd6);
    chk("miss_miss_count", miss_count, 32'd1);
`endif

    step(); dcache_miss_m = 1; lit("miss_both_c0", O_STALL);
    step(); mem_ready = 1; lit("miss_and_ready", O_STALL);
    step(); mem_ready = 0; lit("resume_ignores_miss", O_STALL);
    step(); dcache_miss_m = 0; lit("after_resume", O_DEF);

    step(); dcache_miss_m = 1; lit("miss_before_rst", O_STALL);
    step(); dcache_miss_m = 0; lit("in_miss", O_STALL);
    step(); rst = 1; lit("rst_in_miss", O_RST);
    step(); rst = 0; lit("idle_after_rst", O_DEF);
    step(); mem_ready = 1; lit("ready_ignored_idle", O_DEF);
    step(); clr();

    for (int i = 0; i < 3000; i++) begin
      step();
      rst           = ($urandom_range(63) == 0);
      Rs1_d         = AW'($urandom_range(3));
      Rs2_d         = AW'($urandom_range(3));
      Rs1_e         = AW'($urandom_range(3));
      Rs2_e         = AW'($urandom_range(3));
      Rd_e          = AW'($urandom_range(3));
      Rd_m          = AW'($urandom_range(3));
      Rd_w          = AW'($urandom_range(3));
      RegWrite_e    = 1'($urandom_range(1));
      RegWrite_m    = 1'($urandom_range(1));
      RegWrite_w    = 1'($urandom_range(1));
      ResultSrc_e   = SW'($urandom_range(3));
      PCSrc_e       = ($urandom_range(5) == 0);
      dcache_miss_m = ($urandom_range(7) == 0);
      mem_ready     = ($urandom_range(2) == 0);
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
